// File: rtl/mcu_code_loader_if.sv
// ---------------------------------------------------------------------------
// mcu_code_loader_if
//   Signal bundle between the code loader and its surroundings: the incoming
//   byte stream, the code-RAM write port and the core control/status lines.
//
//   Modports
//     slave  : the loader itself (consumes the stream, drives the write port)
//     master : the byte source / system side (drives the stream and BOOT_REQ)
//
//   Signals
//     rx_data   [7:0]    incoming stream byte
//     rx_valid           rx_data valid
//     rx_ready           loader can accept a byte
//     boot_req           level, rising edge re-enters load mode
//     code_addr [AW-1:0] code-memory write address
//     code_data [7:0]    code-memory write data
//     code_we            one-cycle write strobe per data byte
//     cpu_reset          active-high reset to the 8051 core
//     frame_ok           one-cycle pulse, frame ended with good checksum
//     frame_err          one-cycle pulse, bad checksum or inter-byte timeout
//     err_cnt   [7:0]    saturating count of frame_err pulses
// ---------------------------------------------------------------------------
interface mcu_code_loader_if #(
  parameter int AW = 13
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          boot_req;
  logic [AW-1:0] code_addr;
  logic [7:0]    code_data;
  logic          code_we;
  logic          cpu_reset;
  logic          frame_ok;
  logic          frame_err;
  logic [7:0]    err_cnt;

  modport slave (
    input  rx_data, rx_valid, boot_req,
    output rx_ready, code_addr, code_data, code_we,
           cpu_reset, frame_ok, frame_err, err_cnt
  );

  modport master (
    output rx_data, rx_valid, boot_req,
    input  rx_ready, code_addr, code_data, code_we,
           cpu_reset, frame_ok, frame_err, err_cnt
  );
endinterface

// File: rtl/mcu_code_loader.sv
// ---------------------------------------------------------------------------
// mcu_code_loader
//   Writer side of the 8051 program-memory path. Parses framed code images
//   from a byte stream and writes the payload into code RAM while holding the
//   core in reset. A good zero-length ("run") frame releases the core.
//
//   Frame: A5 | LEN_H LEN_L | ADR_H ADR_L | LEN data bytes | CSUM
//   The 8-bit sum of every byte after A5, including CSUM, must be zero.
//
//   Parameters
//     AW       code address width (addresses wrap modulo 2**AW), must be > 8
//     TIMEOUT  idle clock cycles tolerated between bytes inside a frame
//
//   Ports
//     clk  system clock
//     rst  asynchronous active-high reset
//     bus  mcu_code_loader_if slave modport (stream, write port, status)
// ---------------------------------------------------------------------------
module mcu_code_loader #(
  parameter int AW      = 13,
  parameter int TIMEOUT = 100000
) (
  input logic               clk,
  input logic               rst,
  mcu_code_loader_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_H, LEN_L, ADR_H, ADR_L, DATA, CSUM, FRAME_END
  } state_t;

  state_t        state, state_next;

  logic [15:0]   len;
  logic [AW-9:0] adr_hi;
  logic [AW-1:0] addr_ptr;
  logic [7:0]    sum;
  logic [TW-1:0] timer;
  logic          err_flag;
  logic          is_run;
  logic          cpu_q;
  logic          boot_q;

  logic [AW-1:0] code_addr_q;
  logic [7:0]    code_data_q;
  logic          code_we_q;
  logic [7:0]    err_cnt_q;

  logic          take;
  logic          in_frame;
  logic          timeout_hit;
  logic          boot_rise;

  assign take        = bus.rx_valid & bus.rx_ready;
  assign in_frame    = (state != IDLE) && (state != FRAME_END);
  // The timer reaches TIMEOUT idle cycles on this edge unless a byte arrives.
  assign timeout_hit = in_frame && !take && (timer == TW'(TIMEOUT - 1));
  assign boot_rise   = bus.boot_req & ~boot_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: every arrow consumes one byte, FRAME_END lasts one cycle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (take && bus.rx_data == 8'hA5) state_next = LEN_H;
      LEN_H:     if (take) state_next = LEN_L;
      LEN_L:     if (take) state_next = ADR_H;
      ADR_H:     if (take) state_next = ADR_L;
      ADR_L:     if (take) state_next = (len == 16'd0) ? CSUM : DATA;
      DATA:      if (take && len == 16'd1) state_next = CSUM;
      CSUM:      if (take) state_next = FRAME_END;
      FRAME_END: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timeout_hit)
      state_next = FRAME_END;
  end

  // Output logic. A good run frame drops cpu_reset during FRAME_END itself,
  // unless a BOOT_REQ rising edge is seen in that same cycle.
  always_comb begin
    bus.rx_ready  = (state != FRAME_END);
    bus.frame_ok  = (state == FRAME_END) && !err_flag;
    bus.frame_err = (state == FRAME_END) &&  err_flag;
    bus.cpu_reset = cpu_q &
                    ~((state == FRAME_END) && !err_flag && is_run && !boot_rise);
  end

  assign bus.code_addr = code_addr_q;
  assign bus.code_data = code_data_q;
  assign bus.code_we   = code_we_q;
  assign bus.err_cnt   = err_cnt_q;

  // Frame datapath: length/address capture, checksum, write port, timer,
  // error counter and the core reset register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len         <= '0;
      adr_hi      <= '0;
      addr_ptr    <= '0;
      sum         <= '0;
      timer       <= '0;
      err_flag    <= 1'b0;
      is_run      <= 1'b0;
      cpu_q       <= 1'b1;
      boot_q      <= 1'b0;
      code_addr_q <= '0;
      code_data_q <= '0;
      code_we_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      boot_q    <= bus.boot_req;
      code_we_q <= 1'b0;

      if (!in_frame || take)
        timer <= '0;
      else
        timer <= timer + TW'(1);

      if (take) begin
        unique case (state)
          IDLE: begin
            sum      <= '0;
            err_flag <= 1'b0;
            is_run   <= 1'b0;
          end
          LEN_H: begin
            len[15:8] <= bus.rx_data;
            sum       <= sum + bus.rx_data;
          end
          LEN_L: begin
            len[7:0] <= bus.rx_data;
            sum      <= sum + bus.rx_data;
          end
          ADR_H: begin
            adr_hi <= bus.rx_data[AW-9:0];
            sum    <= sum + bus.rx_data;
          end
          ADR_L: begin
            addr_ptr <= {adr_hi, bus.rx_data};
            is_run   <= (len == 16'd0);
            sum      <= sum + bus.rx_data;
          end
          DATA: begin
            code_we_q   <= 1'b1;
            code_addr_q <= addr_ptr;
            code_data_q <= bus.rx_data;
            addr_ptr    <= addr_ptr + AW'(1);
            len         <= len - 16'd1;
            sum         <= sum + bus.rx_data;
          end
          CSUM: begin
            err_flag <= ((sum + bus.rx_data) != 8'h00);
          end
          default: ;
        endcase
      end

      if (timeout_hit)
        err_flag <= 1'b1;

      if (state == FRAME_END && err_flag && err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;

      if (boot_rise)
        cpu_q <= 1'b1;
      else if (state == FRAME_END && !err_flag && is_run)
        cpu_q <= 1'b0;
    end
  end

endmodule
